// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared arbiter types and helpers: FSM state encoding, a clog2
//            for pointer widths and an index rotate used to walk requesters
//            modulo N.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   // Two-state arbiter FSM; explicit 1-bit encoding
   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Ceiling log2, never below 1 so a pointer always has at least one bit
   function automatic int unsigned arb_clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Rotate an index forward by off positions in a ring of n entries.
   // Callers keep idx < n and off < n, so one conditional subtract suffices.
   function automatic int unsigned arb_rot_idx(input int unsigned idx,
                                               input int unsigned off,
                                               input int unsigned n);
      int unsigned s;
      s = idx + off;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_pick
// Brief    : Combinational round-robin picker. Finds the first set request
//            at or after i_ptr (wrapping) using a doubled request vector.
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N  = 8,
   parameter int PW = arb_clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_pick,
   output logic [PW-1:0] o_pick_idx,
   output logic          o_valid
);

   logic [N-1:0]  w_rot;
   logic [PW-1:0] w_off;

   // Rotate requests so bit 0 is the pointer position, take the lowest set
   // bit, then map that offset back to an absolute requester index
   always_comb begin
      w_rot = N'({i_req, i_req} >> i_ptr);
      w_off = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = PW'(j);
         end
      end
      o_valid    = |i_req;
      o_pick_idx = PW'(arb_rot_idx(32'(i_ptr), 32'(w_off), N));
      o_pick     = o_valid ? (N'(1) << o_pick_idx) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/arb_wrr_hold.sv
`default_nettype none
// ============================================================================
// Module   : arb_wrr_hold
// Brief    : Weighted round-robin arbiter with grant hold. A winner owns the
//            shared req/ack channel for up to its weight in beats, or until
//            it withdraws, then the pointer moves past it.
// Revision : 1.0 - initial release
// ============================================================================
module arb_wrr_hold
   import arb_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   req_i,
   input  logic [N*W-1:0] weight_i,
   output logic [N-1:0]   ack_i,
   output logic           req_o,
   input  logic           ack_o,
   output logic [N-1:0]   gnt_o,
   output logic           busy_o
);

   localparam int PW = arb_clog2(N);
   localparam logic [W-1:0] c_credit_one = W'(1);

   arb_state_t    r_state;
   logic [N-1:0]  r_gnt;
   logic [PW-1:0] r_gnt_idx;
   logic [PW-1:0] r_ptr;
   logic [W-1:0]  r_credit;

   logic [N-1:0]  w_pick;
   logic [PW-1:0] w_pick_idx;
   logic          w_pick_valid;
   logic [W-1:0]  w_weight_pick;
   logic [PW-1:0] w_ptr_next;
   logic          w_in_grant;
   logic          w_req_g;
   logic          w_beat;

   arb_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .i_req      (req_i),
      .i_ptr      (r_ptr),
      .o_pick     (w_pick),
      .o_pick_idx (w_pick_idx),
      .o_valid    (w_pick_valid)
   );

   // Weight field of the candidate winner, sampled only when a grant loads
   always_comb begin
      w_weight_pick = '0;
      for (int i = 0; i < N; i++) begin
         if (w_pick_idx == PW'(i)) begin
            w_weight_pick = weight_i[i*W +: W];
         end
      end
   end

   // Channel gating: only the granted requester reaches the shared resource
   always_comb begin
      w_in_grant = (r_state == ARB_GRANT);
      w_req_g    = |(req_i & r_gnt);
      w_beat     = w_in_grant & w_req_g & ack_o;
      w_ptr_next = PW'(arb_rot_idx(32'(r_gnt_idx), 32'd1, N));
      req_o      = w_in_grant & w_req_g;
      ack_i      = r_gnt & {N{w_beat}};
      busy_o     = w_in_grant;
      gnt_o      = r_gnt;
   end

   // FSM, grant register, pointer and burst credit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ARB_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_ptr     <= '0;
         r_credit  <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_valid) begin
                  r_state   <= ARB_GRANT;
                  r_gnt     <= w_pick;
                  r_gnt_idx <= w_pick_idx;
                  // A zero weight still earns one beat so nobody starves
                  r_credit  <= (w_weight_pick == '0) ? c_credit_one : w_weight_pick;
               end
            end
            ARB_GRANT: begin
               // Exit on withdrawal or on the beat that spends the last credit
               if (!w_req_g || (w_beat && (r_credit == c_credit_one))) begin
                  r_state <= ARB_IDLE;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_next;
               end else if (w_beat) begin
                  r_credit <= r_credit - c_credit_one;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arb_wrr_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_wrr_hold
// Brief    : Directed and randomized self-checking bench for arb_wrr_hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_wrr_hold;

   localparam int N = 8;
   localparam int W = 4;

   logic           clk      = 1'b0;
   logic           rstn     = 1'b0;
   logic [N-1:0]   req_i    = '0;
   logic [N*W-1:0] weight_i = '0;
   logic           ack_o    = 1'b0;
   logic [N-1:0]   ack_i;
   logic           req_o;
   logic [N-1:0]   gnt_o;
   logic           busy_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   arb_wrr_hold #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req_i    (req_i),
      .weight_i (weight_i),
      .ack_i    (ack_i),
      .req_o    (req_o),
      .ack_o    (ack_o),
      .gnt_o    (gnt_o),
      .busy_o   (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn  = 1'b0;
      req_i = '0;
      ack_o = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   logic [7:0] t2_exp [8];
   logic [N-1:0] rq, acked, prev_gnt;
   int wait_cnt [N];
   int max_wait, max_beats, beats, n_grants;
   int viol_onehot, viol_subset, viol_idle;

   initial begin
      // ---------------- 1: reset behaviour ----------------
      weight_i = 32'h1111_1111;
      rstn  = 1'b0;
      req_i = 8'hFF;
      ack_o = 1'b1;
      step(); step(); #1;
      check("rst_gnt",  32'(gnt_o),  32'h00);
      check("rst_ack",  32'(ack_i),  32'h00);
      check("rst_req",  32'(req_o),  32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      rstn = 1'b1;
      step(); #1;
      check("rel_gnt", 32'(gnt_o), 32'h01);
      check("rel_ack", 32'(ack_i), 32'h01);
      step(); #1;
      check("rel_bubble", 32'(gnt_o), 32'h00);
      step(); #1;
      check("rel_next", 32'(gnt_o), 32'h02);

      // ---------------- 2: weight-2 bursts ----------------
      do_reset();
      weight_i = 32'h2222_2222;
      req_i = 8'h05;
      ack_o = 1'b1;
      t2_exp = '{8'h01, 8'h01, 8'h00, 8'h04, 8'h04, 8'h00, 8'h01, 8'h01};
      for (int k = 0; k < 8; k++) begin
         step(); #1;
         check($sformatf("burst_ack%0d", k), 32'(ack_i), 32'(t2_exp[k]));
      end

      // ---------------- 3: early withdraw ----------------
      do_reset();
      weight_i = 32'h0000_5000;
      req_i = 8'h08;
      ack_o = 1'b1;
      step(); #1;
      check("wd_beat1", 32'(ack_i), 32'h08);
      step(); #1;
      check("wd_beat2", 32'(ack_i), 32'h08);
      step();
      req_i = 8'h00;
      #1;
      check("wd_no_ack3", 32'(ack_i), 32'h00);
      check("wd_req_o",   32'(req_o), 32'h0);
      check("wd_busy",    32'(busy_o), 32'h1);
      step(); #1;
      check("wd_idle", 32'(busy_o), 32'h0);
      req_i = 8'h18;
      step(); #1;
      check("wd_ptr4", 32'(gnt_o), 32'h10);

      // ---------------- 4: pointer wrap ----------------
      do_reset();
      weight_i = 32'h1111_1111;
      ack_o = 1'b1;
      req_i = 8'h40;
      step(); #1;
      check("wrap_g6", 32'(gnt_o), 32'h40);
      step();
      req_i = 8'h81;
      #1;
      check("wrap_bub1", 32'(gnt_o), 32'h00);
      step(); #1;
      check("wrap_g7", 32'(gnt_o), 32'h80);
      step(); step(); #1;
      check("wrap_g0", 32'(gnt_o), 32'h01);

      // ---------------- 5: stall holds grant and credit ----------------
      do_reset();
      weight_i = 32'h0000_0003;
      req_i = 8'h01;
      ack_o = 1'b0;
      step(); #1;
      check("stall_gnt", 32'(gnt_o), 32'h01);
      for (int k = 0; k < 10; k++) begin
         step(); #1;
         check($sformatf("stall_hold%0d", k), {gnt_o, ack_i, 7'd0, req_o, 8'd0},
               {8'h01, 8'h00, 7'd0, 1'b1, 8'd0});
      end
      ack_o = 1'b1;
      #1;
      check("stall_b1", 32'(ack_i), 32'h01);
      step(); #1;
      check("stall_b2", 32'(ack_i), 32'h01);
      step(); #1;
      check("stall_b3", 32'(ack_i), 32'h01);
      step(); #1;
      check("stall_end", {ack_i, 7'd0, busy_o}, {8'h00, 8'h00});

      // ---------------- 6a: weight 0 gives one beat ----------------
      do_reset();
      weight_i = 32'h0000_0000;
      req_i = 8'h02;
      ack_o = 1'b1;
      step(); #1;
      check("w0_ack", {gnt_o, ack_i}, {8'h02, 8'h02});
      step(); #1;
      check("w0_exit", 32'(gnt_o), 32'h00);
      step(); #1;
      check("w0_regrant", 32'(gnt_o), 32'h02);

      // ---------------- 6b: random traffic, invariants and fairness ----------------
      do_reset();
      weight_i = {$urandom};
      rq = '0; acked = '0; prev_gnt = '0;
      max_wait = 0; max_beats = 0; beats = 0; n_grants = 0;
      viol_onehot = 0; viol_subset = 0; viol_idle = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rq[i]) begin
               if (acked[i] && ($urandom_range(0, 1) == 1)) begin
                  rq[i] = 1'b0;
                  acked[i] = 1'b0;
                  wait_cnt[i] = 0;
               end
            end else if ($urandom_range(0, 9) < 3) begin
               rq[i] = 1'b1;
            end
         end
         req_i = rq;
         ack_o = ($urandom_range(0, 9) < 7);
         #1;
         if ((gnt_o & (gnt_o - 8'd1)) != 8'd0) viol_onehot++;
         if ((ack_i & ~gnt_o) != 8'd0) viol_subset++;
         if (!busy_o && (req_o || (gnt_o != 8'd0))) viol_idle++;
         if (ack_i != 8'd0) beats++;
         if (beats > max_beats) max_beats = beats;
         acked = acked | ack_i;
         step();
         if (gnt_o == 8'd0) beats = 0;
         if ((gnt_o != 8'd0) && (prev_gnt == 8'd0)) begin
            n_grants++;
            for (int i = 0; i < N; i++) begin
               if (gnt_o[i]) begin
                  if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                  wait_cnt[i] = 0;
               end else if (rq[i]) begin
                  wait_cnt[i]++;
               end
            end
         end
         prev_gnt = gnt_o;
      end
      check("rand_onehot",   32'(viol_onehot), 32'd0);
      check("rand_ack_sub",  32'(viol_subset), 32'd0);
      check("rand_idle_req", 32'(viol_idle),   32'd0);
      check("rand_max_wait", 32'(max_wait <= N - 1), 32'd1);
      check("rand_max_beat", 32'(max_beats <= 15),   32'd1);
      check("rand_activity", 32'(n_grants > 100),    32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
